// File: rtl/fir_tdm_mac.sv
`default_nettype none
// ============================================================================
// Module   : fir_tdm_mac
// Purpose  : Multi-channel time-multiplexed FIR filter. A single shared
//            multiply-accumulate unit runs one tap per cycle over a
//            per-channel circular sample history. Coefficients can be
//            reprogrammed at runtime.
// Options  : FIR_SAT_EN - saturate the output to W_Y bits and add the m_sat
//            port. When undefined, the output keeps the low W_Y bits.
// Revision : 1.0 - initial release
// ============================================================================
module fir_tdm_mac #(
  parameter int N_TAPS = 8,
  parameter int C      = 2,
  parameter int W_X    = 8,
  parameter int W_K    = 8,
  parameter int SHIFT  = 0,
  parameter int W_Y    = 16,
  localparam int W_C   = (C > 1) ? $clog2(C) : 1,
  localparam int W_A   = $clog2(N_TAPS),
  localparam int W_ACC = W_X + W_K + $clog2(N_TAPS)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W_X-1:0] s_data,
  input  logic [W_C-1:0] s_chan,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [W_Y-1:0] m_data,
  output logic [W_C-1:0] m_chan,
`ifdef FIR_SAT_EN
  output logic           m_sat,
`endif
  input  logic           coef_we,
  input  logic [W_A-1:0] coef_addr,
  input  logic [W_K-1:0] coef_wdata,
  output logic           coef_ready
);

  // Full-precision product width and the post-process working width
  // (one guard bit so the rounding offset can never wrap).
  localparam int W_P = W_X + W_K;
  localparam int W_R = W_ACC + 1;

  localparam logic [W_C:0] C_CH_LIM = (W_C + 1)'(C);
  localparam logic [W_A:0] C_N_EXT  = (W_A + 1)'(N_TAPS);
  localparam logic [W_A-1:0] C_LAST = W_A'(N_TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Storage: coefficients, per-channel sample rings and ring head pointers.
  logic [W_K-1:0] coef_q [N_TAPS];
  logic [W_X-1:0] hist_q [C][N_TAPS];
  logic [W_A-1:0] head_q [C];

  logic [W_C-1:0] ch_q, ch_d;
  logic [W_A-1:0] tap_q, tap_d;
  logic [W_ACC-1:0] acc_q, acc_d;
  logic           m_valid_q, m_valid_d;
  logic [W_Y-1:0] m_data_q, m_data_d;
  logic [W_C-1:0] m_chan_q, m_chan_d;
`ifdef FIR_SAT_EN
  logic           m_sat_q, m_sat_d;
`endif

  logic           w_accept;
  logic           w_chan_ok;
  logic           w_coef_wr;
  logic [W_A-1:0] w_head_cur;
  logic [W_A-1:0] w_head_nxt;
  logic [W_A:0]   w_rd_wide;
  logic [W_A-1:0] w_rd_idx;
  logic [W_X-1:0] w_x;
  logic [W_K-1:0] w_k;
  logic [W_P-1:0] w_x_ext;
  logic [W_P-1:0] w_k_ext;
  logic [W_P-1:0] w_prod;
  logic [W_ACC-1:0] w_prod_ext;
  logic signed [W_R-1:0] w_ext;
  logic signed [W_R-1:0] w_shifted;
  logic [W_Y-1:0] w_y;
`ifdef FIR_SAT_EN
  logic           w_clip;
`endif

  // Channel indices at or above C are swallowed without touching state.
  assign w_chan_ok = ({1'b0, s_chan} < C_CH_LIM);
  assign w_accept  = s_valid & s_ready;
  assign w_coef_wr = coef_we & coef_ready;

  // Ring head advance for the incoming channel, wrapping N_TAPS-1 -> 0.
  assign w_head_cur = head_q[s_chan];
  assign w_head_nxt = (w_head_cur == C_LAST) ? '0 : (w_head_cur + W_A'(1));

  // Tap i reads entry (head - i) mod N_TAPS; works for any N_TAPS.
  assign w_rd_wide = {1'b0, head_q[ch_q]} + C_N_EXT - {1'b0, tap_q};
  assign w_rd_idx  = (w_rd_wide >= C_N_EXT) ? W_A'(w_rd_wide - C_N_EXT)
                                            : w_rd_wide[W_A-1:0];

  // Signed multiply done on sign-extended operands; the low W_P bits of the
  // product are the exact two's-complement result.
  assign w_x        = hist_q[ch_q][w_rd_idx];
  assign w_k        = coef_q[tap_q];
  assign w_x_ext    = {{W_K{w_x[W_X-1]}}, w_x};
  assign w_k_ext    = {{W_X{w_k[W_K-1]}}, w_k};
  assign w_prod     = w_x_ext * w_k_ext;
  assign w_prod_ext = {{(W_ACC - W_P){w_prod[W_P-1]}}, w_prod};

  assign w_ext = {acc_q[W_ACC-1], acc_q};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [W_R-1:0] C_HALF = W_R'(1) << (SHIFT - 1);
      // Round half up, then arithmetic shift.
      assign w_shifted = (w_ext + C_HALF) >>> SHIFT;
    end else begin : g_no_round
      assign w_shifted = w_ext;
    end
  endgenerate

`ifdef FIR_SAT_EN
  localparam logic signed [W_R-1:0] C_YMAX = {{(W_R - W_Y + 1){1'b0}}, {(W_Y - 1){1'b1}}};
  localparam logic signed [W_R-1:0] C_YMIN = {{(W_R - W_Y + 1){1'b1}}, {(W_Y - 1){1'b0}}};
  logic w_hi;
  logic w_lo;
  assign w_hi   = (w_shifted > C_YMAX);
  assign w_lo   = (w_shifted < C_YMIN);
  assign w_clip = w_hi | w_lo;
  assign w_y    = w_hi ? C_YMAX[W_Y-1:0] :
                  w_lo ? C_YMIN[W_Y-1:0] : w_shifted[W_Y-1:0];
`else
  // Two's-complement wrap: the bits above W_Y are intentionally dropped.
  logic w_unused_hi;
  assign w_unused_hi = ^w_shifted[W_R-1:W_Y];
  assign w_y         = w_shifted[W_Y-1:0];
`endif

  // Next-state and datapath control for the IDLE -> MAC -> OUT sequence.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    tap_d      = tap_q;
    acc_d      = acc_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_chan_d   = m_chan_q;
`ifdef FIR_SAT_EN
    m_sat_d    = m_sat_q;
`endif
    s_ready    = 1'b0;
    coef_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        s_ready    = 1'b1;
        coef_ready = 1'b1;
        if (s_valid && w_chan_ok) begin
          ch_d    = s_chan;
          tap_d   = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + w_prod_ext;
        tap_d = tap_q + W_A'(1);
        if (tap_q == C_LAST) begin
          tap_d   = '0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (!m_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = w_y;
          m_chan_d  = ch_q;
`ifdef FIR_SAT_EN
          m_sat_d   = w_clip;
`endif
        end else if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator, tap counter and output holding registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ch_q      <= '0;
      tap_q     <= '0;
      acc_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_chan_q  <= '0;
`ifdef FIR_SAT_EN
      m_sat_q   <= 1'b0;
`endif
    end else begin
      ch_q      <= ch_d;
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_chan_q  <= m_chan_d;
`ifdef FIR_SAT_EN
      m_sat_q   <= m_sat_d;
`endif
    end
  end

  // Coefficient writes and per-channel sample history updates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_TAPS; i++) begin
        coef_q[i] <= '0;
      end
      for (int c = 0; c < C; c++) begin
        head_q[c] <= '0;
        for (int i = 0; i < N_TAPS; i++) begin
          hist_q[c][i] <= '0;
        end
      end
    end else begin
      if (w_coef_wr) begin
        coef_q[coef_addr] <= coef_wdata;
      end
      if (w_accept && w_chan_ok) begin
        head_q[s_chan]             <= w_head_nxt;
        hist_q[s_chan][w_head_nxt] <= s_data;
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_chan  = m_chan_q;
`ifdef FIR_SAT_EN
  assign m_sat   = m_sat_q;
`endif

endmodule
`default_nettype wire
